// File: rtl/sme_record_feeder.sv
// -----------------------------------------------------------------------------
// sme_record_feeder
//
// Upstream stage of the string-matching engine. A handshaked byte stream is
// framed into string (STR) and pattern (PAT) records. Each record is buffered
// in full. The record is then replayed to the matcher as one gap-free burst on
// chardata, qualified by isstring or ispattern. After a pattern burst the block
// waits for the matcher's sme_valid pulse, with a timeout, before it accepts
// more input.
//
// Framing bytes (recognised only while receiving):
//   0x01  start a STR record (discards any open record)
//   0x02  start a PAT record (discards any open record)
//   0x0A  end the current record
//   other bytes are payload when a record is open, and are dropped otherwise
//
// Handshake: a byte transfers on a rising clk edge where in_valid & in_ready.
// in_ready is high only while the block is receiving and reset is low. The
// producer may change in_data freely while in_valid is low.
//
// Ports
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous, active-high
//   in_valid     in   1  in_data valid
//   in_data      in   8  input byte
//   in_ready     out  1  block can take a byte this cycle
//   chardata     out  8  character to the matcher (registered, holds when idle)
//   isstring     out  1  string burst active (registered)
//   ispattern    out  1  pattern burst active (registered)
//   sme_valid    in   1  matcher result-valid pulse (used only while waiting)
//   busy         out  1  block is not in the receive state
//   err_len      out  1  one-cycle pulse: record dropped, over length
//   err_timeout  out  1  one-cycle pulse: no sme_valid within TIMEOUT cycles
//   pat_count    out  8  patterns completed (wraps 255 -> 0)
// -----------------------------------------------------------------------------
module sme_record_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       err_len,
    output logic       err_timeout,
    output logic [7:0] pat_count
);

    // The buffer is sized for the larger of the two record kinds. The
    // per-record limit is applied by cur_max.
    localparam int BUF_MAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int LEN_W   = $clog2(BUF_MAX + 1);
    localparam int IDX_W   = (BUF_MAX > 1) ? $clog2(BUF_MAX) : 1;
    localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_RECV = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] TY_NONE = 2'd0;
    localparam logic [1:0] TY_STR  = 2'd1;
    localparam logic [1:0] TY_PAT  = 2'd2;

    localparam logic [7:0] B_STR = 8'h01;
    localparam logic [7:0] B_PAT = 8'h02;
    localparam logic [7:0] B_END = 8'h0A;

    logic [1:0]       state;
    logic [1:0]       rec_type;
    logic [LEN_W-1:0] rec_len;
    logic             overflow;
    logic [LEN_W-1:0] play_idx;
    logic [TMR_W-1:0] timer;
    logic [7:0]       rec_buf [BUF_MAX];

    logic             accept;
    logic             byte_start;
    logic             byte_end;
    logic             byte_char;
    logic             buf_wr;
    logic             play_done;
    logic [LEN_W-1:0] cur_max;

    // -------------------------------------------------------------------------
    // Handshake and byte classification
    // -------------------------------------------------------------------------
    assign in_ready = (state == ST_RECV) & ~reset;
    assign busy     = (state != ST_RECV);
    assign accept   = in_valid & in_ready;

    assign byte_start = accept & ((in_data == B_STR) | (in_data == B_PAT));
    assign byte_end   = accept & (in_data == B_END);
    assign byte_char  = accept & ~byte_start & ~byte_end & (rec_type != TY_NONE);

    always_comb begin
        cur_max = LEN_W'(STR_MAX);
        if (rec_type == TY_PAT) begin
            cur_max = LEN_W'(PAT_MAX);
        end
    end

    // A payload byte is stored only while the record still has room. Later
    // bytes only mark the record as overflowed, so the buffer is never
    // written out of range.
    assign buf_wr = byte_char & (rec_len < cur_max);

    // The burst ends when every stored character has been presented.
    assign play_done = (play_idx == rec_len);

    // -------------------------------------------------------------------------
    // Record buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_MAX; i++) begin
                rec_buf[i] <= '0;
            end
        end else if (buf_wr) begin
            rec_buf[rec_len[IDX_W-1:0]] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: RECV -> PLAY -> (STR) RECV
    //                           -> (PAT) WAIT -> RECV
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RECV;
            rec_type    <= TY_NONE;
            rec_len     <= '0;
            overflow    <= 1'b0;
            play_idx    <= '0;
            timer       <= '0;
            chardata    <= '0;
            isstring    <= 1'b0;
            ispattern   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            pat_count   <= '0;
        end else begin
            // Error outputs are single-cycle pulses.
            err_len     <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                ST_RECV: begin
                    if (byte_start) begin
                        rec_type <= (in_data == B_STR) ? TY_STR : TY_PAT;
                        rec_len  <= '0;
                        overflow <= 1'b0;
                    end else if (byte_end) begin
                        // A terminator with no open record, or with an empty
                        // record, is ignored.
                        if ((rec_type != TY_NONE) && (rec_len != '0)) begin
                            if (overflow) begin
                                err_len  <= 1'b1;
                                rec_type <= TY_NONE;
                                rec_len  <= '0;
                                overflow <= 1'b0;
                            end else begin
                                state    <= ST_PLAY;
                                play_idx <= '0;
                            end
                        end
                    end else if (byte_char) begin
                        // The length saturates at the limit for this record kind.
                        if (rec_len < cur_max) begin
                            rec_len <= rec_len + LEN_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (play_done) begin
                        // The qualifiers drop for at least this one cycle. The
                        // earliest next burst is one full record away, so
                        // consecutive bursts are always separated.
                        isstring  <= 1'b0;
                        ispattern <= 1'b0;
                        rec_type  <= TY_NONE;
                        timer     <= '0;
                        state     <= (rec_type == TY_PAT) ? ST_WAIT : ST_RECV;
                    end else begin
                        chardata  <= rec_buf[play_idx[IDX_W-1:0]];
                        isstring  <= (rec_type == TY_STR);
                        ispattern <= (rec_type == TY_PAT);
                        play_idx  <= play_idx + LEN_W'(1);
                    end
                end

                ST_WAIT: begin
                    // A result on the last allowed cycle still counts. sme_valid
                    // takes priority over the timeout.
                    if (sme_valid) begin
                        pat_count <= pat_count + 8'd1;
                        state     <= ST_RECV;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_RECV;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: begin
                    state <= ST_RECV;
                end
            endcase
        end
    end

endmodule
